div_issue_ctrl: RTL and testbench

//  EX-stage sequencer for the multi-cycle serial divider. Accepts DIV/DIVU ops from EX, latches

---
 rtl/div_issue_ctrl_pkg.sv | 28 ++
 rtl/div_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_div_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg: shared encodings and payload types for the divider issue sequencer.
//   ISS_*            FSM state encodings (2-bit)
//   DIV_START/STOP   divider start handshake levels
//   DIV_RES_*        divider ready levels
//   ZERO_WORD        32-bit zero
//   div_res_t        {remainder, quotient} payload returned by serial_div
package div_issue_ctrl_pkg;

   localparam int unsigned DATA_W       = 32;
   localparam int unsigned MAX_WAIT_DEF = 40;

   localparam logic [1:0] ISS_IDLE = 2'd0;
   localparam logic [1:0] ISS_BUSY = 2'd1;
   localparam logic [1:0] ISS_DONE = 2'd2;

   localparam logic DIV_START         = 1'b1;
   localparam logic DIV_STOP          = 1'b0;
   localparam logic DIV_RES_READY     = 1'b1;
   localparam logic DIV_RES_NOT_READY = 1'b0;

   localparam logic [DATA_W-1:0] ZERO_WORD = '0;

   typedef struct packed {
      logic [DATA_W-1:0] rem;
      logic [DATA_W-1:0] quo;
   } div_res_t;

endpackage

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage sequencer for the multi-cycle serial divider.
// Latches DIV/DIVU operands, drives the divider start/annul handshake, stalls the
// pipeline while the divide is in flight, and produces a one-cycle HI/LO write.
// Ports:
//   clk, rst (async, active-low)
//   ex_div_i/ex_signed_i/ex_op1_i/ex_op2_i  op request from EX
//   flush_i                                 cancels any in-flight divide
//   div_start_o/div_annul_o/div_signed_o/div_op1_o/div_op2_o  to serial_div
//   div_result_i/div_ready_i                from serial_div
//   stallreq_o (combinational)              pipeline stall request
//   whilo_o/hi_o/lo_o                       HI/LO write-back
//   timeout_o                               sticky divider-timeout error
module div_issue_ctrl
   import div_issue_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_div_i,
   input  logic        ex_signed_i,
   input  logic [31:0] ex_op1_i,
   input  logic [31:0] ex_op2_i,
   input  logic        flush_i,
   output logic        div_start_o,
   output logic        div_annul_o,
   output logic        div_signed_o,
   output logic [31:0] div_op1_o,
   output logic [31:0] div_op2_o,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i,
   output logic        stallreq_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        timeout_o
);

   localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              start_q, start_d;
   logic              signed_q, signed_d;
   logic [31:0]       op1_q, op1_d;
   logic [31:0]       op2_q, op2_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic              whilo_q, whilo_d;
   logic              timeout_q, timeout_d;
   logic              annul_c;
   logic              stall_c;
   div_res_t          res;

   assign res = div_result_i;

   // State register and output flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ISS_IDLE;
         cnt_q     <= '0;
         start_q   <= DIV_STOP;
         signed_q  <= 1'b0;
         op1_q     <= ZERO_WORD;
         op2_q     <= ZERO_WORD;
         hi_q      <= ZERO_WORD;
         lo_q      <= ZERO_WORD;
         whilo_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         start_q   <= start_d;
         signed_q  <= signed_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         whilo_q   <= whilo_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state, handshake and stall logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      start_d   = start_q;
      signed_d  = signed_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      whilo_d   = 1'b0;
      timeout_d = timeout_q;
      annul_c   = 1'b0;
      stall_c   = 1'b0;

      case (state_q)
         ISS_IDLE: begin
            // Flush beats a new issue; operands are captured only here
            if (ex_div_i && !flush_i) begin
               stall_c  = 1'b1;
               signed_d = ex_signed_i;
               op1_d    = ex_op1_i;
               op2_d    = ex_op2_i;
               start_d  = DIV_START;
               cnt_d    = '0;
               state_d  = ISS_BUSY;
            end
         end
         ISS_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (flush_i) begin
               // Flush wins even over a same-cycle ready; result is dropped
               annul_c = 1'b1;
               start_d = DIV_STOP;
               state_d = ISS_IDLE;
            end else if (div_ready_i == DIV_RES_READY) begin
               hi_d    = res.rem;
               lo_d    = res.quo;
               whilo_d = 1'b1;
               start_d = DIV_STOP;
               state_d = ISS_DONE;
            end else if (cnt_q == CNT_LAST) begin
               timeout_d = 1'b1;
               annul_c   = 1'b1;
               start_d   = DIV_STOP;
               state_d   = ISS_IDLE;
            end else begin
               stall_c = 1'b1;
            end
         end
         ISS_DONE: begin
            // One-cycle gap lets the divider drop back to free; a waiting DIV re-issues from IDLE
            stall_c = ex_div_i;
            state_d = ISS_IDLE;
         end
         default: begin
            start_d = DIV_STOP;
            state_d = ISS_IDLE;
         end
      endcase
   end

   assign div_start_o  = start_q;
   assign div_annul_o  = annul_c;
   assign div_signed_o = signed_q;
   assign div_op1_o    = op1_q;
   assign div_op2_o    = op2_q;
   assign stallreq_o   = stall_c;
   assign whilo_o      = whilo_q;
   assign hi_o         = hi_q;
   assign lo_o         = lo_q;
   assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed bench for div_issue_ctrl with a behavioural divider stand-in.
module tb_div_issue_ctrl;

   localparam int LAT      = 34;
   localparam int MAX_WAIT = 40;

   logic        clk;
   logic        rst;
   logic        ex_div_i;
   logic        ex_signed_i;
   logic [31:0] ex_op1_i;
   logic [31:0] ex_op2_i;
   logic        flush_i;
   logic        div_start_o;
   logic        div_annul_o;
   logic        div_signed_o;
   logic [31:0] div_op1_o;
   logic [31:0] div_op2_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;
   logic        stallreq_o;
   logic        whilo_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        timeout_o;

   int n_tests = 0;
   int n_fail  = 0;
   int whilo_pulses = 0;
   logic never_ready;
   logic [5:0] stub_cnt;

   div_issue_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_div_i     (ex_div_i),
      .ex_signed_i  (ex_signed_i),
      .ex_op1_i     (ex_op1_i),
      .ex_op2_i     (ex_op2_i),
      .flush_i      (flush_i),
      .div_start_o  (div_start_o),
      .div_annul_o  (div_annul_o),
      .div_signed_o (div_signed_o),
      .div_op1_o    (div_op1_o),
      .div_op2_o    (div_op2_o),
      .div_result_i (div_result_i),
      .div_ready_i  (div_ready_i),
      .stallreq_o   (stallreq_o),
      .whilo_o      (whilo_o),
      .hi_o         (hi_o),
      .lo_o         (lo_o),
      .timeout_o    (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference divide: {remainder, quotient}, 0/0 on zero divisor
   function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb, sq, sr;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = a; sb = b;
         sq = sa / sb;
         sr = sa % sb;
         return {sr, sq};
      end
      return {a % b, a / b};
   endfunction

   // Divider stand-in: ready LAT+1 cycles after start, held until start drops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stub_cnt     <= '0;
         div_ready_i  <= 1'b0;
         div_result_i <= '0;
      end else if (div_annul_o || !div_start_o) begin
         stub_cnt     <= '0;
         div_ready_i  <= 1'b0;
         div_result_i <= '0;
      end else if (!never_ready) begin
         if (stub_cnt == 6'(LAT)) begin
            div_ready_i  <= 1'b1;
            div_result_i <= div_model(div_signed_o, div_op1_o, div_op2_o);
         end else begin
            stub_cnt <= stub_cnt + 6'd1;
         end
      end
   end

   always @(posedge clk) if (rst && whilo_o) whilo_pulses++;

   task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: actual %h required %h", tag, what, act, exp);
      end
   endtask

   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
      ex_signed_i = s;
      ex_op1_i    = a;
      ex_op2_i    = b;
      ex_div_i    = 1'b1;
   endtask

   // Issue one op at a negedge in IDLE, wait for release, check the DONE cycle
   task automatic run_one(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit chain,
                          input logic ns, input logic [31:0] na, input logic [31:0] nb);
      int cyc;
      bit released;
      issue(s, a, b);
      #1 chk(tag, "stall_issue", 32'(stallreq_o), 32'd1);
      cyc = 0;
      released = 0;
      while (!released && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (cyc == 3) begin
            chk(tag, "start", 32'(div_start_o), 32'd1);
            chk(tag, "op1", div_op1_o, a);
            chk(tag, "op2", div_op2_o, b);
            chk(tag, "sgn", 32'(div_signed_o), 32'(s));
            ex_op1_i = ~a;
            ex_op2_i = b + 32'd1;
         end
         if (!stallreq_o) released = 1;
      end
      chk(tag, "released", 32'(released), 32'd1);
      chk(tag, "stall_cycles", 32'(cyc), 32'(LAT + 2));
      if (chain) issue(ns, na, nb);
      else ex_div_i = 1'b0;
      @(negedge clk);
      chk(tag, "whilo", 32'(whilo_o), 32'd1);
      chk(tag, "hi", hi_o, exp_hi);
      chk(tag, "lo", lo_o, exp_lo);
      chk(tag, "start_done", 32'(div_start_o), 32'd0);
      chk(tag, "stall_done", 32'(stallreq_o), 32'(chain));
      chk(tag, "timeout", 32'(timeout_o), 32'd0);
      @(negedge clk);
      chk(tag, "whilo_off", 32'(whilo_o), 32'd0);
      chk(tag, "stall_idle", 32'(stallreq_o), 32'(chain));
   endtask

   typedef struct {
      string       name;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int cyc;
      vecs[0] = '{"divu_100_7",  1'b0, 32'd100,        32'd7,        32'h00000002, 32'h0000000E};
      vecs[1] = '{"div_m7_2",    1'b1, 32'hFFFFFFF9,   32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[2] = '{"divu_5_0",    1'b0, 32'd5,          32'd0,        32'h00000000, 32'h00000000};
      vecs[3] = '{"div_20_m3",   1'b1, 32'd20,         32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFA};
      vecs[4] = '{"divu_max_16", 1'b0, 32'hFFFFFFFF,   32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

      rst = 1'b0; ex_div_i = 1'b0; ex_signed_i = 1'b0; ex_op1_i = '0; ex_op2_i = '0;
      flush_i = 1'b0; never_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset", "start", 32'(div_start_o), 32'd0);
      chk("reset", "whilo", 32'(whilo_o), 32'd0);
      chk("reset", "hi", hi_o, 32'd0);
      chk("reset", "lo", lo_o, 32'd0);
      chk("reset", "timeout", 32'(timeout_o), 32'd0);
      chk("reset", "stall", 32'(stallreq_o), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      foreach (vecs[i])
         run_one(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0, 1'b0, 32'd0, 32'd0);

      // Flush in IDLE blocks the issue
      ex_div_i = 1'b1; flush_i = 1'b1;
      #1 chk("flush_idle", "stall", 32'(stallreq_o), 32'd0);
      @(negedge clk);
      chk("flush_idle", "start", 32'(div_start_o), 32'd0);
      ex_div_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);

      // Flush 10 cycles into BUSY
      issue(1'b0, 32'd50, 32'd5);
      repeat (10) @(negedge clk);
      flush_i = 1'b1; ex_div_i = 1'b0;
      #1;
      chk("flush_busy", "annul", 32'(div_annul_o), 32'd1);
      chk("flush_busy", "stall", 32'(stallreq_o), 32'd0);
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      chk("flush_busy", "annul_off", 32'(div_annul_o), 32'd0);
      chk("flush_busy", "start", 32'(div_start_o), 32'd0);
      chk("flush_busy", "whilo", 32'(whilo_o), 32'd0);
      @(negedge clk);
      run_one("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 0, 1'b0, 32'd0, 32'd0);

      // Flush and ready in the same cycle: flush wins
      issue(1'b0, 32'd77, 32'd7);
      cyc = 0;
      while (!div_ready_i && cyc < 100) begin @(negedge clk); cyc++; end
      chk("flush_ready", "ready_seen", 32'(div_ready_i), 32'd1);
      flush_i = 1'b1; ex_div_i = 1'b0;
      #1 chk("flush_ready", "annul", 32'(div_annul_o), 32'd1);
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_ready", "whilo", 32'(whilo_o), 32'd0);
      chk("flush_ready", "start", 32'(div_start_o), 32'd0);
      @(negedge clk);

      // Back-to-back: second op stalls through DONE, restarts from IDLE
      run_one("b2b_a", 1'b0, 32'd8, 32'd2, 32'd0, 32'd4, 1, 1'b0, 32'd9, 32'd4);
      run_one("b2b_b", 1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 0, 1'b0, 32'd0, 32'd0);

      // Timeout with a divider that never answers
      never_ready = 1'b1;
      issue(1'b0, 32'd1, 32'd1);
      cyc = 0;
      #1;
      while (stallreq_o && cyc < 100) begin @(negedge clk); cyc++; end
      chk("timeout", "stall_cycles", 32'(cyc), 32'(MAX_WAIT));
      chk("timeout", "annul", 32'(div_annul_o), 32'd1);
      chk("timeout", "flag_pre", 32'(timeout_o), 32'd0);
      ex_div_i = 1'b0;
      @(negedge clk);
      chk("timeout", "flag", 32'(timeout_o), 32'd1);
      chk("timeout", "annul_off", 32'(div_annul_o), 32'd0);
      chk("timeout", "start", 32'(div_start_o), 32'd0);
      chk("timeout", "whilo", 32'(whilo_o), 32'd0);
      repeat (3) @(negedge clk);
      chk("timeout", "sticky", 32'(timeout_o), 32'd1);
      never_ready = 1'b0;

      // Asynchronous reset mid-BUSY
      issue(1'b1, 32'd123, 32'd4);
      repeat (5) @(negedge clk);
      chk("rst_busy", "start_pre", 32'(div_start_o), 32'd1);
      ex_div_i = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_busy", "start", 32'(div_start_o), 32'd0);
      chk("rst_busy", "annul", 32'(div_annul_o), 32'd0);
      chk("rst_busy", "timeout", 32'(timeout_o), 32'd0);
      chk("rst_busy", "hi", hi_o, 32'd0);
      chk("rst_busy", "lo", lo_o, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      chk("total", "whilo_pulses", 32'(whilo_pulses), 32'd8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
